// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranger: level codes, FSM state encoding,
// default timing/threshold constants and the echo-width classifier.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_ECHO = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_t;

  localparam logic [1:0] LVL_EMPTY = 2'b00;
  localparam logic [1:0] LVL_LOW   = 2'b01;
  localparam logic [1:0] LVL_MID   = 2'b10;
  localparam logic [1:0] LVL_FULL  = 2'b11;

  localparam int DEF_TRIG_CYCLES     = 500;
  localparam int DEF_PERIOD_CYCLES   = 3000000;
  localparam int DEF_ECHO_MAX_CYCLES = 1500000;
  localparam int DEF_THR_HIGH        = 60000;
  localparam int DEF_THR_MID         = 300000;
  localparam int DEF_THR_LOW         = 900000;
  localparam int DEF_STABLE_N        = 3;
  localparam int DEF_CNT_W           = 22;

  // A width equal to a threshold lands in the emptier bin.
  function automatic logic [1:0] classify(input int unsigned width,
                                          input int unsigned thr_high,
                                          input int unsigned thr_mid,
                                          input int unsigned thr_low);
    logic [1:0] code;
    if (width < thr_high) begin
      code = LVL_FULL;
    end else if (width < thr_mid) begin
      code = LVL_MID;
    end else if (width < thr_low) begin
      code = LVL_LOW;
    end else begin
      code = LVL_EMPTY;
    end
    return code;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for an asynchronous sensor input with rise/fall
// detection against the registered copy of the synchronized level.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync_out = sync_r;
  assign rise     = sync_r & ~prev_r;
  assign fall     = ~sync_r & prev_r;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic sensor front end: periodic trigger, echo width timing, level
// classification with debounce, and timeout fault reporting.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES     = DEF_TRIG_CYCLES,
  parameter int PERIOD_CYCLES   = DEF_PERIOD_CYCLES,
  parameter int ECHO_MAX_CYCLES = DEF_ECHO_MAX_CYCLES,
  parameter int THR_HIGH        = DEF_THR_HIGH,
  parameter int THR_MID         = DEF_THR_MID,
  parameter int THR_LOW         = DEF_THR_LOW,
  parameter int STABLE_N        = DEF_STABLE_N,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic [1:0]       level,
  output logic             level_valid,
  output logic [CNT_W-1:0] echo_cycles,
  output logic             fault
);

  localparam int SW = $clog2(STABLE_N + 1);

  state_t           state_r;
  logic [CNT_W-1:0] period_cnt_r;
  logic [CNT_W-1:0] phase_cnt_r;
  logic [CNT_W-1:0] width_cnt_r;
  logic             trig_r;
  logic [1:0]       level_r;
  logic             level_valid_r;
  logic [CNT_W-1:0] echo_cycles_r;
  logic             fault_r;
  logic [1:0]       cand_r;
  logic [SW-1:0]    stable_cnt_r;

  logic             echo_s;
  logic             echo_rise_s;
  logic             echo_fall_s;
  logic [1:0]       code_s;
  logic [1:0]       cand_nxt_s;
  logic [SW-1:0]    cnt_nxt_s;

  echo_sync u_echo_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (echo),
    .sync_out (echo_s),
    .rise     (echo_rise_s),
    .fall     (echo_fall_s)
  );

  // Debounce candidate/count that a completed measurement would commit.
  always_comb begin
    code_s     = classify(32'(width_cnt_r), THR_HIGH, THR_MID, THR_LOW);
    cand_nxt_s = cand_r;
    cnt_nxt_s  = stable_cnt_r;
    if (code_s == cand_r) begin
      if (stable_cnt_r >= SW'(STABLE_N)) begin
        cnt_nxt_s = SW'(STABLE_N);
      end else begin
        cnt_nxt_s = stable_cnt_r + SW'(1);
      end
    end else begin
      cand_nxt_s = code_s;
      cnt_nxt_s  = SW'(1);
    end
  end

  // Measurement FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      period_cnt_r  <= '0;
      phase_cnt_r   <= '0;
      width_cnt_r   <= '0;
      trig_r        <= 1'b0;
      level_r       <= LVL_EMPTY;
      level_valid_r <= 1'b0;
      echo_cycles_r <= '0;
      fault_r       <= 1'b0;
      cand_r        <= LVL_EMPTY;
      stable_cnt_r  <= '0;
    end else begin
      level_valid_r <= 1'b0;
      period_cnt_r  <= period_cnt_r + CNT_W'(1);
      case (state_r)
        ST_IDLE: begin
          period_cnt_r <= '0;
          if (enable) begin
            state_r     <= ST_TRIG;
            trig_r      <= 1'b1;
            phase_cnt_r <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_TRIG: begin
          if (phase_cnt_r == CNT_W'(TRIG_CYCLES - 1)) begin
            state_r     <= ST_WAIT_ECHO;
            trig_r      <= 1'b0;
            phase_cnt_r <= '0;
          end else begin
            phase_cnt_r <= phase_cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_ECHO: begin
          if (echo_rise_s) begin
            state_r     <= ST_MEASURE;
            width_cnt_r <= CNT_W'(1);
          end else if (phase_cnt_r == CNT_W'(ECHO_MAX_CYCLES - 1)) begin
            state_r      <= ST_HOLDOFF;
            fault_r      <= 1'b1;
            stable_cnt_r <= '0;
          end else begin
            phase_cnt_r <= phase_cnt_r + CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (echo_fall_s) begin
            state_r       <= ST_HOLDOFF;
            echo_cycles_r <= width_cnt_r;
            level_valid_r <= 1'b1;
            fault_r       <= 1'b0;
            cand_r        <= cand_nxt_s;
            stable_cnt_r  <= cnt_nxt_s;
            if (cnt_nxt_s == SW'(STABLE_N)) begin
              level_r <= cand_nxt_s;
            end else begin
              level_r <= level_r;
            end
          end else if (width_cnt_r == CNT_W'(ECHO_MAX_CYCLES - 1)) begin
            // Echo stuck high: saturate the reported width and flag it.
            state_r       <= ST_HOLDOFF;
            echo_cycles_r <= CNT_W'(ECHO_MAX_CYCLES);
            fault_r       <= 1'b1;
            stable_cnt_r  <= '0;
          end else begin
            width_cnt_r <= width_cnt_r + CNT_W'(1);
          end
        end
        ST_HOLDOFF: begin
          if (period_cnt_r == CNT_W'(PERIOD_CYCLES - 1)) begin
            period_cnt_r <= '0;
            phase_cnt_r  <= '0;
            if (enable) begin
              state_r <= ST_TRIG;
              trig_r  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_HOLDOFF;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          trig_r  <= 1'b0;
        end
      endcase
    end
  end

  assign trig        = trig_r;
  assign level       = level_r;
  assign level_valid = level_valid_r;
  assign echo_cycles = echo_cycles_r;
  assign fault       = fault_r;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger: table of echo widths, scoreboard of
// expected per-measurement results, plus timing checks on trigger and faults.
module tb_ultrasonic_ranger;

  localparam int CNT_W  = 22;
  localparam int PERIOD = 200;
  localparam int TRIGW  = 4;
  localparam int NVEC   = 15;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             echo;
  logic             trig;
  logic [1:0]       level;
  logic             level_valid;
  logic [CNT_W-1:0] echo_cycles;
  logic             fault;

  typedef struct {
    int         ec;
    bit         flt;
    int         nvalid;
    logic [1:0] lvl;
  } exp_t;

  typedef struct {
    int   width;
    bit   drop;
    exp_t e;
  } vec_t;

  vec_t vecs[NVEC];
  exp_t sb[$];

  int nchecks = 0;
  int nerrors = 0;
  int ncyc = 0;
  int nrises = 0;

  ultrasonic_ranger #(
    .TRIG_CYCLES     (4),
    .PERIOD_CYCLES   (200),
    .ECHO_MAX_CYCLES (150),
    .THR_HIGH        (20),
    .THR_MID         (50),
    .THR_LOW         (100),
    .STABLE_N        (2),
    .CNT_W           (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .echo        (echo),
    .trig        (trig),
    .level       (level),
    .level_valid (level_valid),
    .echo_cycles (echo_cycles),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: trigger timing, level_valid pulses, scoreboard pop near period end.
  initial begin
    bit         trig_q = 1'b0;
    int         last_rise = -1;
    int         since = 0;
    int         vcount = 0;
    int         thigh = 0;
    logic [1:0] lvl_at_v = 2'b00;
    exp_t       e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        trig_q = 1'b0;
        continue;
      end
      if (trig && !trig_q) begin
        if (last_rise >= 0) check("trig_period", ncyc - last_rise, PERIOD);
        last_rise = ncyc;
        since = 0;
        vcount = 0;
        thigh = 0;
        nrises++;
      end else begin
        since++;
      end
      if (trig) thigh++;
      if (!trig && trig_q) check("trig_width", thigh, TRIGW);
      if (level_valid) begin
        vcount++;
        lvl_at_v = level;
      end
      if (since == PERIOD - 2 && sb.size() > 0) begin
        e = sb.pop_front();
        check("echo_cycles", int'(echo_cycles), e.ec);
        check("fault", int'(fault), int'(e.flt));
        check("level", int'(level), int'(e.lvl));
        check("level_valid_pulses", vcount, e.nvalid);
        if (e.nvalid > 0) check("level_at_valid", int'(lvl_at_v), int'(e.lvl));
      end
      trig_q = trig;
    end
  end

  // Driver: reset, then one table entry per measurement period.
  initial begin
    int  t;
    int  rises_before;
    bit  abort = 1'b0;
    vecs[0]  = '{30,  1'b0, '{30,  1'b0, 1, 2'b00}};
    vecs[1]  = '{30,  1'b0, '{30,  1'b0, 1, 2'b10}};
    vecs[2]  = '{20,  1'b0, '{20,  1'b0, 1, 2'b10}};
    vecs[3]  = '{20,  1'b0, '{20,  1'b0, 1, 2'b10}};
    vecs[4]  = '{19,  1'b0, '{19,  1'b0, 1, 2'b10}};
    vecs[5]  = '{19,  1'b0, '{19,  1'b0, 1, 2'b11}};
    vecs[6]  = '{0,   1'b0, '{19,  1'b1, 0, 2'b11}};
    vecs[7]  = '{30,  1'b0, '{30,  1'b0, 1, 2'b11}};
    vecs[8]  = '{160, 1'b0, '{150, 1'b1, 0, 2'b11}};
    vecs[9]  = '{30,  1'b0, '{30,  1'b0, 1, 2'b11}};
    vecs[10] = '{80,  1'b0, '{80,  1'b0, 1, 2'b11}};
    vecs[11] = '{30,  1'b0, '{30,  1'b0, 1, 2'b11}};
    vecs[12] = '{80,  1'b0, '{80,  1'b0, 1, 2'b11}};
    vecs[13] = '{30,  1'b0, '{30,  1'b0, 1, 2'b11}};
    vecs[14] = '{80,  1'b1, '{80,  1'b0, 1, 2'b11}};

    rst_n  = 1'b0;
    enable = 1'b1;
    echo   = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_trig", int'(trig), 0);
    check("rst_level", int'(level), 0);
    check("rst_level_valid", int'(level_valid), 0);
    check("rst_echo_cycles", int'(echo_cycles), 0);
    check("rst_fault", int'(fault), 0);
    rst_n = 1'b1;

    for (int v = 0; v < NVEC && !abort; v++) begin
      t = 0;
      while (!trig && t < 2 * PERIOD) begin
        @(negedge clk);
        t++;
      end
      if (!trig) begin
        check("trig_rise_wait", int'(trig), 1);
        abort = 1'b1;
        break;
      end
      t = 0;
      while (trig && t < 4 * TRIGW) begin
        @(negedge clk);
        t++;
      end
      if (trig) begin
        check("trig_fall_wait", int'(trig), 0);
        abort = 1'b1;
        break;
      end
      sb.push_back(vecs[v].e);
      if (vecs[v].width == 0) begin
        for (int i = 1; i <= 150; i++) begin
          @(negedge clk);
          if (i == 149) check("fault_before_timeout", int'(fault), 0);
          if (i == 150) check("fault_at_timeout", int'(fault), 1);
        end
      end else begin
        repeat (3) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < vecs[v].width; i++) begin
          if (vecs[v].drop && i == 5) enable = 1'b0;
          @(negedge clk);
        end
        echo = 1'b0;
      end
    end

    rises_before = nrises;
    repeat (2 * PERIOD) @(negedge clk);
    check("no_trig_after_disable", nrises, rises_before);
    check("trig_idle_low", int'(trig), 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
